// File: rtl/qtcore_io_frontend_if.sv
// Core-facing signal bundle of the qtcore pin front-end.
// All signals are single-cycle levels sampled on the rising clk edge; there is no valid/ready pairing.
interface qtcore_io_frontend_if;
    logic scan_enable;
    logic scan_data;
    logic proc_en;
    logic btn_clean;
    logic core_scan_out;
    logic core_halt;

    modport master (
        output scan_enable,
        output scan_data,
        output proc_en,
        output btn_clean,
        input  core_scan_out,
        input  core_halt
    );

    modport slave (
        input  scan_enable,
        input  scan_data,
        input  proc_en,
        input  btn_clean,
        output core_scan_out,
        output core_halt
    );
endinterface

// File: rtl/qtcore_io_frontend.sv
// Pin front-end for qtcore: input synchronisers, scan/run arbitration FSM,
// scan bit counter with wrap pulse, halt status, button debounce and MISO mux.
module qtcore_io_frontend #(
    parameter int CHAIN_LEN       = 120,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(CHAIN_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scan_csn,
    input  logic                      proc_csn,
    input  logic                      scan_din,
    input  logic                      btn_raw,
    qtcore_io_frontend_if.master      core,
    output logic                      miso,
    output logic                      halted,
    output logic [CNT_W-1:0]          scan_bit_count,
    output logic                      chain_wrap,
    output logic [1:0]                state_dbg
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scan_csn_sync;
    logic [SYNC_STAGES-1:0] proc_csn_sync;
    logic [SYNC_STAGES-1:0] scan_din_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   s_scan;
    logic                   s_proc;
    logic                   s_din;
    logic                   s_btn;

    logic                   scan_data_q;
    logic                   btn_clean_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   scan_enable_c;
    logic                   proc_en_c;
    logic                   halted_c;
    logic                   miso_c;

    // Chip-select chains idle high so a reset never looks like a select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_csn_sync <= '1;
            proc_csn_sync <= '1;
            scan_din_sync <= '0;
            btn_sync      <= '0;
        end else begin
            scan_csn_sync <= {scan_csn_sync[SYNC_STAGES-2:0], scan_csn};
            proc_csn_sync <= {proc_csn_sync[SYNC_STAGES-2:0], proc_csn};
            scan_din_sync <= {scan_din_sync[SYNC_STAGES-2:0], scan_din};
            btn_sync      <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign s_scan = ~scan_csn_sync[SYNC_STAGES-1];
    assign s_proc = ~proc_csn_sync[SYNC_STAGES-1];
    assign s_din  = scan_din_sync[SYNC_STAGES-1];
    assign s_btn  = btn_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scan select always wins, including over an active or halted run.
    always_comb begin
        state_next    = state;
        scan_enable_c = 1'b0;
        proc_en_c     = 1'b0;
        halted_c      = 1'b0;
        miso_c        = 1'b0;
        case (state)
            IDLE: begin
                if (s_scan) begin
                    state_next = SCAN;
                end else if (s_proc) begin
                    state_next = RUN;
                end
            end
            SCAN: begin
                scan_enable_c = 1'b1;
                miso_c        = core.core_scan_out;
                if (!s_scan) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                proc_en_c = 1'b1;
                if (s_scan) begin
                    state_next = SCAN;
                end else if (!s_proc) begin
                    state_next = IDLE;
                end else if (core.core_halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                halted_c = 1'b1;
                miso_c   = 1'b1;
                if (s_scan) begin
                    state_next = SCAN;
                end else if (!s_proc) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_bit_count <= '0;
            chain_wrap     <= 1'b0;
        end else if (state != SCAN) begin
            scan_bit_count <= '0;
            chain_wrap     <= 1'b0;
        end else if (scan_bit_count == CNT_W'(CHAIN_LEN - 1)) begin
            scan_bit_count <= '0;
            chain_wrap     <= 1'b1;
        end else begin
            scan_bit_count <= scan_bit_count + CNT_W'(1);
            chain_wrap     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_data_q <= 1'b0;
        end else begin
            scan_data_q <= s_din;
        end
    end

    // The counter only runs while the sampled button disagrees with the clean value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_clean_q <= 1'b0;
            db_cnt      <= '0;
        end else if (s_btn == btn_clean_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_clean_q <= s_btn;
            db_cnt      <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign core.scan_enable = scan_enable_c;
    assign core.proc_en     = proc_en_c;
    assign core.scan_data   = scan_data_q;
    assign core.btn_clean   = btn_clean_q;
    assign halted           = halted_c;
    assign miso             = miso_c;
    assign state_dbg        = state;
endmodule

// File: doc/qtcore_io_frontend.md
Name: qtcore_io_frontend

Overview:
Parametrised pin front-end between the TinyTapeout io pins and the qtcore accumulator microcontroller. It synchronises the raw SPI-style pins and arbitrates scan versus run mode with a small state machine. It counts scan-chain bits with wrap detection, latches halt status, debounces the user button and drives the shared MISO pin. It replaces the purely combinational pin mux used previously; its outputs connect directly to the core's scan_enable, proc_en, scan_in and btn_in.

Parameters:
CHAIN_LEN, 120, scan-chain length in bits; bit counter wraps at this value (>=2)
SYNC_STAGES, 2, flip-flop stages on each raw input (>=2)
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples needed to change btn_clean (>=1)
CNT_W, $clog2(CHAIN_LEN), scan bit counter width (derived; not overridden)

Ports:
clk  input  1  system clock (io_in[0])
rst  input  1  asynchronous, active-low reset
scan_csn  input  1  raw scan chip-select, active low
proc_csn  input  1  raw processor-enable chip-select, active low
scan_din  input  1  raw serial scan data
btn_raw  input  1  raw push button
core_scan_out  input  1  serial scan data returned from core
core_halt  input  1  core halt flag
scan_enable  output  1  to core: shift scan chain
scan_data  output  1  to core: registered serial scan data
proc_en  output  1  to core: run enable
btn_clean  output  1  debounced button to core
miso  output  1  shared serial out pin
halted  output  1  sticky halt status
scan_bit_count  output  CNT_W  bits shifted since entering SCAN, modulo CHAIN_LEN
chain_wrap  output  1  one-cycle pulse when the counter wraps

Behaviour:
- Reset (rst=0, async): all sync flops cleared to the inactive value (csn chains to 1, data and button to 0). State=IDLE. All outputs 0, counter 0, debounce counter 0.
- Sync: each raw input passes SYNC_STAGES flops; s_scan=!sync(scan_csn), s_proc=!sync(proc_csn).
- FSM, registered, evaluated every edge:
  - IDLE: s_scan -> SCAN; else s_proc -> RUN.
  - SCAN: !s_scan -> IDLE. Scan has priority, so s_proc is ignored while s_scan=1.
  - RUN: s_scan -> SCAN, which aborts the run; else !s_proc -> IDLE; else core_halt -> HALTED.
  - HALTED: s_scan -> SCAN; else !s_proc -> IDLE; else stay.
- Both chip-selects low on the same sample resolves to SCAN.
- Outputs:
  - scan_enable = (state==SCAN).
  - proc_en = (state==RUN); it drops in HALTED.
  - halted = (state==HALTED).
- Latency: scan_enable or proc_en asserts on the (SYNC_STAGES+1)th rising edge after the raw csn falls. Deassert latency is the same.
- scan_data: register of sync(scan_din), updated every cycle, so it is aligned with scan_enable.
- Scan counter:
  - Cleared on any cycle where state!=SCAN.
  - Increments on each cycle with state==SCAN.
  - At CHAIN_LEN-1 the next value is 0 and chain_wrap=1 for exactly that one cycle (registered pulse).
- MISO, combinational from state:
  - SCAN: miso=core_scan_out.
  - RUN or HALTED: miso=halted, so it is 0 while running and 1 once halted.
  - IDLE: miso=0.
- Debounce:
  - Counter resets whenever the synchronised button equals btn_clean.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES, btn_clean takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Re-entry requires a fresh synchronised csn.

Test Plan:
- Reset: hold rst=0 with scan_csn=0 and btn_raw=1 -> all outputs 0, miso=0; release and wait 3 edges (SYNC_STAGES=2) -> scan_enable=1 on edge 3.
- Scan wrap with CHAIN_LEN=8: scan_csn=0 for 20 cycles after entry -> scan_bit_count 0..7,0..7,0..3; chain_wrap high only on the cycles where the count goes 7->0 (two pulses); miso tracks core_scan_out.
- Priority: scan_csn and proc_csn both dropped on the same cycle -> SCAN, proc_en stays 0. Then raise scan_csn -> IDLE, then RUN 3 cycles later.
- Halt: in RUN pulse core_halt for 1 cycle -> next edge proc_en=0, halted=1, miso=1 and they remain so after core_halt falls; raise proc_csn -> halted=0 and miso=0 after 3 edges.
- Debounce, DEBOUNCE_CYCLES=4: btn_raw high 3 cycles then low -> btn_clean stays 0; btn_raw high 6 cycles -> btn_clean=1 exactly 4 cycles after the synchronised rise.
- Reset mid-scan: rst=0 at scan_bit_count=5 -> count 0 and scan_enable=0 immediately (async), with no chain_wrap pulse.
